// File: rtl/fake_module_unit.sv
// Observer for a single asynchronous net: synchronises it, reports level and edge
// pulses, counts edges with saturation and flags when the level has been quiet.
module fake_module_unit #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             G1,
    input  logic             clear,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             stable_o
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0]       fall_cnt_q, fall_cnt_d;
    logic [STAB_W-1:0]      stable_cnt_q, stable_cnt_d;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [STAB_W-1:0] stab_sat_inc(input logic [STAB_W-1:0] v);
        return (v >= STAB_MAX) ? STAB_MAX : v + STAB_W'(1);
    endfunction

    assign level_o  = sync_q[SYNC_STAGES-1];
    assign rise_o   = level_o & ~prev_q;
    assign fall_o   = ~level_o & prev_q;
    assign rise_cnt = rise_cnt_q;
    assign fall_cnt = fall_cnt_q;
    assign stable_o = (stable_cnt_q == STAB_MAX);

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], G1};
        prev_d       = level_o;
        rise_cnt_d   = rise_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        stable_cnt_d = stable_cnt_q;
        // Clear only affects the statistics; the synchroniser keeps running.
        if (clear) begin
            rise_cnt_d   = '0;
            fall_cnt_d   = '0;
            stable_cnt_d = '0;
        end else begin
            if (rise_o) rise_cnt_d = cnt_sat_inc(rise_cnt_q);
            if (fall_o) fall_cnt_d = cnt_sat_inc(fall_cnt_q);
            if (rise_o | fall_o) stable_cnt_d = '0;
            else                 stable_cnt_d = stab_sat_inc(stable_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            stable_cnt_q <= '0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            rise_cnt_q   <= rise_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

endmodule

// File: tb/tb_fake_module_unit.sv
// Bench for fake_module_unit: a delay-line model checked every cycle on two
// instances (16-bit and 3-bit counters) plus directed literal expectations.
module tb_fake_module_unit;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst_n, G1, clear;

    logic        level_a, rise_a, fall_a, stable_a;
    logic [15:0] rise_cnt_a, fall_cnt_a;
    logic        level_b, rise_b, fall_b, stable_b;
    logic [2:0]  rise_cnt_b, fall_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fake_module_unit #(.SYNC_STAGES(SYNC), .CNT_W(16), .STABLE_CYCLES(STABLE)) dut_a (
        .clk(clk), .rst_n(rst_n), .G1(G1), .clear(clear),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a),
        .rise_cnt(rise_cnt_a), .fall_cnt(fall_cnt_a), .stable_o(stable_a)
    );

    fake_module_unit #(.SYNC_STAGES(SYNC), .CNT_W(3), .STABLE_CYCLES(STABLE)) dut_b (
        .clk(clk), .rst_n(rst_n), .G1(G1), .clear(clear),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b),
        .rise_cnt(rise_cnt_b), .fall_cnt(fall_cnt_b), .stable_o(stable_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Behavioural model: level is simply G1 as captured SYNC edges ago.
    bit m_valid = 1'b0;
    bit hist[$];
    bit m_level, m_prev, m_r, m_f;
    int m_rise, m_fall, m_rise3, m_fall3, m_stab;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            hist.delete();
            m_level = 1'b0; m_prev = 1'b0;
            m_rise = 0; m_fall = 0; m_rise3 = 0; m_fall3 = 0; m_stab = 0;
        end else if (m_valid) begin
            m_r = m_level && !m_prev;
            m_f = !m_level && m_prev;
            if (clear) begin
                m_rise = 0; m_fall = 0; m_rise3 = 0; m_fall3 = 0; m_stab = 0;
            end else begin
                if (m_r) begin m_rise = sat(m_rise + 1, 65535); m_rise3 = sat(m_rise3 + 1, 7); end
                if (m_f) begin m_fall = sat(m_fall + 1, 65535); m_fall3 = sat(m_fall3 + 1, 7); end
                m_stab = (m_r || m_f) ? 0 : sat(m_stab + 1, STABLE);
            end
            hist.push_back(G1);
            m_prev  = m_level;
            m_level = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("level_a",  level_a,  m_level);
            check("rise_a",   rise_a,   m_level && !m_prev);
            check("fall_a",   fall_a,   !m_level && m_prev);
            check("rcnt_a",   rise_cnt_a, m_rise);
            check("fcnt_a",   fall_cnt_a, m_fall);
            check("stable_a", stable_a, m_stab == STABLE);
            check("level_b",  level_b,  m_level);
            check("rise_b",   rise_b,   m_level && !m_prev);
            check("fall_b",   fall_b,   !m_level && m_prev);
            check("rcnt_b",   rise_cnt_b, m_rise3);
            check("fcnt_b",   fall_cnt_b, m_fall3);
            check("stable_b", stable_b, m_stab == STABLE);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic g, input int n);
        G1 = g;
        cyc(n);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cyc(n);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; G1 = 1'b1; clear = 1'b0;
        // Reset held with G1 high, then release.
        cyc(3);
        check("rst_level", level_a, 0);
        check("rst_rcnt",  rise_cnt_a, 0);
        check("rst_stable", stable_a, 0);
        rst_n = 1'b1;
        cyc(2);
        check("rel_level", level_a, 1);
        check("rel_rise",  rise_a, 1);
        cyc(1);
        check("rel_rcnt",  rise_cnt_a, 1);
        check("rel_rise_gone", rise_a, 0);

        // Stability after reset with G1 quiet, then a toggle.
        G1 = 1'b0;
        do_reset(1);
        cyc(3);
        check("stab_3", stable_a, 0);
        cyc(1);
        check("stab_4", stable_a, 1);
        G1 = 1'b1;
        cyc(2);
        check("tog_rise", rise_a, 1);
        check("tog_stab_still", stable_a, 1);
        cyc(1);
        check("tog_stab_drop", stable_a, 0);
        cyc(3);
        check("tog_stab_3", stable_a, 0);
        cyc(1);
        check("tog_stab_back", stable_a, 1);

        // Clear colliding with a rise pulse.
        drive(1'b0, 5);
        G1 = 1'b1;
        cyc(2);
        check("clr_rise", rise_a, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("clr_rcnt",  rise_cnt_a, 0);
        check("clr_fcnt",  fall_cnt_a, 0);
        check("clr_level", level_a, 1);

        // Edge counting with 10-cycle spacing.
        G1 = 1'b0;
        do_reset(1);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        check("ec_rcnt", rise_cnt_a, 2);
        check("ec_fcnt", fall_cnt_a, 1);

        // Saturation of the 3-bit instance over 9 rising edges.
        G1 = 1'b0;
        do_reset(1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        cyc(4);
        check("sat_rcnt_b", rise_cnt_b, 7);
        check("sat_fcnt_b", fall_cnt_b, 7);
        check("sat_rcnt_a", rise_cnt_a, 9);

        // Reset in the middle of operation.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        cyc(4);
        check("mid_rcnt5", rise_cnt_a, 5);
        check("mid_stable_pre", stable_a, 1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("mid_rcnt0",  rise_cnt_a, 0);
        check("mid_stable", stable_a, 0);
        cyc(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
